divider: RTL and testbench
==========================

// Module: divider
//
// PURPOSE
//   Sequential restoring unsigned divider; the inverse of the 4x4 array multiplier.
//   Takes a 2*WIDTH-bit dividend (P) and a WIDTH-bit divisor (D).
//   Returns quotient Q and remainder R, with P = Q*D + R and R < D.
//   One quotient bit is produced per clock, under a start/busy/done handshake.
//   Sits beside the multiplier in the arithmetic datapath.
//
// PARAMETERS
//   WIDTH  4  Divisor/remainder width. Dividend and quotient are 2*WIDTH bits.
//
// PORTS
//   clk       in   1        Clock; all state changes on the rising edge.
//   rst_n     in   1        Asynchronous active-low reset.
//   start     in   1        Operation request; sampled only in IDLE.
//   P         in   2*WIDTH  Dividend; captured on the accepted start.
//   D         in   WIDTH    Divisor; captured on the accepted start.
//   busy      out  1        High while in RUN.
//   done      out  1        One-cycle pulse: Q/R/div_zero just updated.
//   Q         out  2*WIDTH  Quotient; holds until the next completion.
//   R         out  WIDTH    Remainder; holds until the next completion.
//   div_zero  out  1        Divide-by-zero flag (see CONFIGURATION).
//
// BEHAVIOUR
//   - Reset, and rst_n low at any time including mid-operation:
//     - state=IDLE; busy=0, done=0, Q=0, R=0, div_zero=0.
//     - Working registers are cleared.
//     - An in-flight operation is discarded; no done is produced.
//   - States:
//     - IDLE: wait for start.
//     - RUN: iterate; a down-counter cnt starts at 2*WIDTH.
//   - IDLE, start=1 (edge E0):
//     - Capture P into shift register dvd and D into dsr.
//     - Clear partial remainder rem (WIDTH bits).
//     - Set cnt=2*WIDTH and go to RUN.
//   - RUN, each edge:
//     - t = {rem, dvd[MSB]} (WIDTH+1 bits).
//     - If t >= {1'b0,dsr}: rem = t - dsr, and shift 1 into the quotient LSB.
//     - Else: rem = t[WIDTH-1:0], and shift 0 into the quotient LSB.
//     - Shift dvd left by one; decrement cnt.
//     - The compare is full WIDTH+1-bit unsigned; no truncation before the compare.
//   - Completion, on the edge where cnt goes 1 -> 0 (edge E0+2*WIDTH):
//     - Load Q and R, set done=1, return to IDLE.
//     - Latency: done is high in the cycle after the 2*WIDTH-th edge following E0.
//     - With WIDTH=4 that is 8 edges.
//   - done is high for exactly one cycle. busy is 1 from after E0 through the completion edge.
//   - start while busy=1 is ignored: no capture, and in-flight operands are unaffected.
//   - start in the cycle done=1 (state already IDLE) is accepted, giving back-to-back operations.
//   - P and D may change freely after capture.
//   - Q, R and div_zero change only on completion or reset.
//
// CONFIGURATION
//   Macro DIVIDER_DIVZERO_EN
//   - Undefined:
//     - div_zero is tied to 0.
//     - D=0 runs the full 2*WIDTH iterations. The compare is always true, so:
//       Q = all ones, R = P[WIDTH-1:0].
//   - Defined:
//     - If the captured D==0, skip RUN.
//     - On the next edge after E0: Q = all ones, R = P[WIDTH-1:0], div_zero=1, done=1.
//     - Latency is 1 edge; busy stays 0.
//     - div_zero is cleared on the next non-zero completion.
//
// TESTING
//   1. Reset: hold rst_n=0 with start=1 and random P/D.
//      -> busy=0, done=0, Q=0, R=0, div_zero=0. No activity until release.
//   2. P=8'd200, D=4'd7, one-cycle start.
//      -> done pulses 8 edges later; Q=8'd28, R=4'd4; busy high 8 cycles.
//   3. Boundary operands, each run separately:
//      - P=8'd255, D=1 -> Q=8'd255, R=0.
//      - P=8'd5, D=9 -> Q=0, R=5.
//      - P=8'd255, D=15 -> Q=8'd17, R=0.
//   4. Handshake:
//      - P=100, D=3 in flight; pulse start with P=9, D=2 at cycle 3.
//        -> ignored; result Q=33, R=1.
//      - Start P=9, D=2 in the done cycle.
//        -> accepted; Q=4, R=1 after 8 more edges.
//   5. Reset mid-operation: start P=200, D=7; drop rst_n at edge 4.
//      -> busy=0, Q=0, no done.
//      - New start after release -> correct result.
//   6. Divide by zero: P=8'h5A, D=0.
//      - Without macro: done after 8 edges, Q=8'hFF, R=4'hA, div_zero=0.
//      - With DIVIDER_DIVZERO_EN: done after 1 edge, div_zero=1, same Q/R.
//      - Next op P=6, D=3 -> div_zero=0.

Source files
------------

// File: rtl/divider.sv
// Sequential restoring unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_DIVZERO_EN: short-circuit a zero divisor in one edge and raise div_zero.
module divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] P,
    input  logic [WIDTH-1:0]   D,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Q,
    output logic [WIDTH-1:0]   R,
    output logic               div_zero
);

    localparam int            CW       = $clog2(2 * WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(2 * WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DZERO
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     t;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        t        = {rem, dvd[2*WIDTH-1]};
        qbit     = (t >= {1'b0, dsr});
        rem_next = qbit ? WIDTH'(t - {1'b0, dsr}) : t[WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
`ifdef DIVIDER_DIVZERO_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= P;
                        dsr <= D;
                        rem <= '0;
                        cnt <= CNT_INIT;
`ifdef DIVIDER_DIVZERO_EN
                        if (D == '0) begin
                            state <= DZERO;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= {dvd[2*WIDTH-2:0], qbit};
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        Q     <= {dvd[2*WIDTH-2:0], qbit};
                        R     <= rem_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef DIVIDER_DIVZERO_EN
                        div_zero <= 1'b0;
`endif
                    end
                end
                DZERO: begin
                    // Same result the full iteration would give for D=0.
                    Q     <= '1;
                    R     <= dvd[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef DIVIDER_DIVZERO_EN
                    div_zero <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DIVIDER_DIVZERO_EN
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed boundary/handshake scenarios plus randomized operands
// checked against an arithmetic reference model.
module tb_divider;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] P;
    logic [W-1:0]   D;
    logic           busy;
    logic           done;
    logic [2*W-1:0] Q;
    logic [W-1:0]   R;
    logic           div_zero;

    int checks   = 0;
    int failures = 0;

    divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .P        (P),
        .D        (D),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, with the zero-divisor result defined as all ones / low dividend bits.
    function automatic void model(input logic [2*W-1:0] p, input logic [W-1:0] d,
                                  output logic [2*W-1:0] q, output logic [W-1:0] r,
                                  output int lat, output logic dz);
        int pi, di;
        pi = int'(p);
        di = int'(d);
        lat = 2 * W;
        dz  = 1'b0;
        if (di == 0) begin
            q = '1;
            r = p[W-1:0];
`ifdef DIVIDER_DIVZERO_EN
            lat = 1;
            dz  = 1'b1;
`endif
        end else begin
            q = (2*W)'(pi / di);
            r = W'(pi % di);
        end
    endfunction

    // Drive a start at the current point; returns #1 after the accepting edge with operands scrambled.
    task automatic launch(input logic [2*W-1:0] p, input logic [W-1:0] d);
        start = 1'b1;
        P     = p;
        D     = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        P     = 8'($urandom);
        D     = 4'($urandom);
    endtask

    // Count edges until done is seen (#1 after each edge); also counts busy-high samples.
    task automatic wait_done(output int n, output int busy_n);
        bit seen;
        seen   = 1'b0;
        busy_n = busy ? 1 : 0;
        n      = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        if (!seen) n = 999;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        P     = 8'($urandom);
        D     = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, Q, R, div_zero} !== '0) begin
                failures++;
                $display("FAIL reset[%0d]: busy=%0b done=%0b Q=%0d R=%0d dz=%0b, want all 0",
                         i, busy, done, Q, R, div_zero);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_single();
        int n, bn;
        @(negedge clk);
        launch(8'd200, 4'd7);
        wait_done(n, bn);
        checks++;
        if (n !== 8 || bn !== 8 || Q !== 8'd28 || R !== 4'd4 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL single_200_7: lat=%0d busy_cycles=%0d Q=%0d R=%0d dz=%0b, want 8 8 28 4 0",
                     n, bn, Q, R, div_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || Q !== 8'd28 || R !== 4'd4) begin
            failures++;
            $display("FAIL done_pulse: done=%0b Q=%0d R=%0d, want 0 28 4", done, Q, R);
        end
    endtask

    task automatic test_boundary();
        logic [2*W-1:0] ps [3] = '{8'd255, 8'd5, 8'd255};
        logic [W-1:0]   ds [3] = '{4'd1, 4'd9, 4'd15};
        logic [2*W-1:0] qs [3] = '{8'd255, 8'd0, 8'd17};
        logic [W-1:0]   rs [3] = '{4'd0, 4'd5, 4'd0};
        int n, bn;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(ps[i], ds[i]);
            wait_done(n, bn);
            checks++;
            if (n !== 8 || Q !== qs[i] || R !== rs[i]) begin
                failures++;
                $display("FAIL boundary_%0d_%0d: lat=%0d Q=%0d R=%0d, want 8 %0d %0d",
                         ps[i], ds[i], n, Q, R, qs[i], rs[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int n, bn;
        @(negedge clk);
        launch(8'd100, 4'd3);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        P     = 8'd9;
        D     = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bn);
        checks++;
        if (n !== 5 || Q !== 8'd33 || R !== 4'd1) begin
            failures++;
            $display("FAIL start_while_busy: remaining=%0d Q=%0d R=%0d, want 5 33 1", n, Q, R);
        end
        launch(8'd9, 4'd2);
        wait_done(n, bn);
        checks++;
        if (n !== 8 || Q !== 8'd4 || R !== 4'd1) begin
            failures++;
            $display("FAIL back_to_back: lat=%0d Q=%0d R=%0d, want 8 4 1", n, Q, R);
        end
    endtask

    task automatic test_reset_mid_op();
        int n, bn, stray;
        @(negedge clk);
        launch(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 8'd0 || R !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset: busy=%0b done=%0b Q=%0d R=%0d, want 0 0 0 0", busy, done, Q, R);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL mid_reset_quiet: %0d cycles with activity, want 0", stray);
        end
        launch(8'd200, 4'd7);
        wait_done(n, bn);
        checks++;
        if (n !== 8 || Q !== 8'd28 || R !== 4'd4) begin
            failures++;
            $display("FAIL after_reset_op: lat=%0d Q=%0d R=%0d, want 8 28 4", n, Q, R);
        end
    endtask

    task automatic test_div_zero();
        logic [2*W-1:0] eq;
        logic [W-1:0]   er;
        int             el, n, bn;
        logic           edz;
        model(8'h5A, 4'd0, eq, er, el, edz);
        @(negedge clk);
        launch(8'h5A, 4'd0);
        wait_done(n, bn);
        checks++;
        if (n !== el || Q !== 8'hFF || R !== 4'hA || div_zero !== edz || bn !== (el == 1 ? 0 : 8)) begin
            failures++;
            $display("FAIL div_zero: lat=%0d busy_cycles=%0d Q=%0h R=%0h dz=%0b, want %0d %0d ff a %0b",
                     n, bn, Q, R, div_zero, el, (el == 1 ? 0 : 8), edz);
        end
        launch(8'd6, 4'd3);
        wait_done(n, bn);
        checks++;
        if (n !== 8 || Q !== 8'd2 || R !== 4'd0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_clear: lat=%0d Q=%0d R=%0d dz=%0b, want 8 2 0 0", n, Q, R, div_zero);
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] p, eq;
        logic [W-1:0]   d, er;
        int             el, n, bn;
        logic           edz;
        for (int i = 0; i < 40; i++) begin
            p = 8'($urandom);
            d = (i % 8 == 7) ? 4'd0 : 4'($urandom);
            model(p, d, eq, er, el, edz);
            // Alternate between idle gaps and starts issued in the done cycle.
            if (i % 2 == 0) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(negedge clk);
            end
            launch(p, d);
            wait_done(n, bn);
            checks++;
            if (n !== el || Q !== eq || R !== er || div_zero !== edz) begin
                failures++;
                $display("FAIL random_%0d p=%0d d=%0d: lat=%0d Q=%0d R=%0d dz=%0b, want %0d %0d %0d %0b",
                         i, p, d, n, Q, R, div_zero, el, eq, er, edz);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        P     = '0;
        D     = '0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_boundary();
        test_handshake();
        test_reset_mid_op();
        test_div_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
